nco_tone_sequencer: RTL and testbench
=====================================

// Module: nco_tone_sequencer
// PURPOSE
//  Sequences the NCO through a programmable list of tones (phase increments). Each tone is held
//  for a set number of output samples, one pass or looped. The block drives the NCO's phi_inc_i
//  and clken, and gates clken with downstream backpressure. Every NCO output sample is tagged
//  with its tone index by tracking the NCO's fixed pipeline latency. It sits between the OFDM
//  control/config logic and the NCO instance.
// PARAMETERS
//  APR     32  phase increment / accumulator width (matches the NCO apr)
//  NTONE   8   tone table depth
//  LOG2NT  3   log2(NTONE); width of tone indices
//  DWW     16  dwell counter width
//  LAT     6   NCO latency in clken-enabled cycles from phi_inc_i to valid fsin_o/fcos_o
// PORTS
//  clk            in   1       system clock
//  reset          in   1       synchronous, active-high reset
//  cfg_we         in   1       tone table write strobe
//  cfg_addr       in   LOG2NT  tone table write address
//  cfg_data       in   APR     phase increment written to table[cfg_addr]
//  last_tone      in   LOG2NT  index of the final tone in the sequence (0..NTONE-1)
//  dwell          in   DWW     samples per tone minus 1 (0 = 1 sample)
//  loop_en        in   1       1: wrap from last_tone back to tone 0; 0: single pass
//  start          in   1       1-cycle pulse; begins a sequence when IDLE
//  stop           in   1       1-cycle pulse; aborts issuing and drains the pipe
//  dn_ready       in   1       downstream can accept a sample this cycle
//  nco_out_valid  in   1       NCO out_valid
//  nco_phi_inc    out  APR     to NCO phi_inc_i (registered)
//  nco_clken      out  1       to NCO clken
//  samp_valid     out  1       current NCO output sample belongs to the sequence
//  samp_tone      out  LOG2NT  tone index of the current sample
//  samp_last      out  1       current sample is the last of the sequence
//  busy           out  1       state != IDLE
//  done           out  1       1-cycle pulse when DRAIN completes
// BEHAVIOUR
//  - Reset: state=IDLE, nco_phi_inc=0, tone/dwell counters=0, tag pipe cleared. All outputs
//    read 0. Table contents are also cleared to 0.
//  - Reset mid-sequence aborts immediately: no drain and no done pulse.
//  - Table: write on cfg_we at any time. A write to the active tone takes effect at that tone's
//    next load. last_tone, dwell and loop_en are sampled on start and held for the whole run.
//  - FSM IDLE->RUN on start. This loads tone=0, dcnt=0 and nco_phi_inc=table[0].
//  - start while busy is ignored.
//  - nco_clken = (state==RUN || state==DRAIN) && dn_ready; it is combinational.
//  - RUN: each cycle with nco_clken=1 issues one sample at the current tone.
//    - dcnt<dwell_q: dcnt++.
//    - Otherwise dcnt=0 and the next tone is chosen:
//      - tone<last_q: tone++ and load table[tone+1].
//      - tone==last_q && loop_en_q: tone=0 and load table[0].
//      - tone==last_q && !loop_en_q: go to DRAIN; this sample is marked last.
//    - No advance when dn_ready=0; all state holds.
//  - stop in RUN moves to DRAIN at the next edge. An issue on that same cycle is still counted.
//    No further samples are marked last.
//  - stop in IDLE or DRAIN is ignored. start and stop in the same cycle while IDLE: start wins.
//  - DRAIN: nco_clken still follows dn_ready, issued tags are invalid, and a drain counter counts
//    LAT enabled cycles. Then the FSM goes to IDLE with done=1 for one cycle. nco_phi_inc holds
//    its last value.
//  - Tag pipe: LAT stages of {v,tone,last}. It shifts only when nco_clken=1.
//    - Stage-0 input: v=(state==RUN), the current tone, and the last flag.
//    - The head aligns with the NCO output for the same issued sample.
//    - samp_valid = nco_clken & nco_out_valid & head.v; samp_tone and samp_last come from the head.
//      samp_last is qualified by samp_valid.
//  - Widths: dcnt is DWW bits, compared unsigned with dwell_q. Tone indices are LOG2NT bits.
//    last_tone>=NTONE is not supported.
// TESTING
//  1. table={100,200,300}, last_tone=2, dwell=3, loop_en=0, dn_ready=1, start -> phi_inc is 100
//     x4, 200 x4, 300 x4. samp_valid is asserted for 12 samples with tags 0,0,0,0,1,1,1,1,2,2,2,2,
//     the first arriving LAT clken-cycles after the first issue. samp_last is asserted on the 12th
//     sample. done pulses LAT cycles after the last issue.
//  2. Same setup with loop_en=1 -> tones cycle 0,1,2,0,... with no gap at the wrap. Apply stop
//     after 7 issues -> exactly 7 (or 8 if issuing in the stop cycle) tagged samples, samp_last
//     never asserted, then done.
//  3. dn_ready toggles 1010... -> nco_clken mirrors it. Tags stay aligned to samples, with no
//     loss or duplication versus test 1.
//  4. dwell=0, last_tone=0, table[0]=0x40000000 -> one tagged sample with samp_last=1, then done.
//  5. Reset asserted during RUN at sample 5 -> next cycle busy=0, nco_clken=0, samp_valid=0,
//     phi_inc=0, and no done pulse.
//  6. start while busy and cfg_we to the active tone -> the run is unchanged. The new value
//     appears at the next load of that index.

Source files
------------

// File: rtl/nco_tone_sequencer.sv
// Steps the NCO through a tone table, tagging each output sample; tags trail issues by LAT enabled cycles.
// Backpressure: dn_ready gates nco_clken directly, so counters, table loads and the tag pipe all hold while it is low.
module nco_tone_sequencer #(
    parameter int APR    = 32,
    parameter int NTONE  = 8,
    parameter int LOG2NT = 3,
    parameter int DWW    = 16,
    parameter int LAT    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [LOG2NT-1:0] cfg_addr,
    input  logic [APR-1:0]    cfg_data,
    input  logic [LOG2NT-1:0] last_tone,
    input  logic [DWW-1:0]    dwell,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              dn_ready,
    input  logic              nco_out_valid,
    output logic [APR-1:0]    nco_phi_inc,
    output logic              nco_clken,
    output logic              samp_valid,
    output logic [LOG2NT-1:0] samp_tone,
    output logic              samp_last,
    output logic              busy,
    output logic              done
);
    localparam int DRW = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [APR-1:0]    table_q [NTONE];
    logic [LOG2NT-1:0] tone, last_q, tone_inc;
    logic [DWW-1:0]    dcnt, dwell_q;
    logic              loop_q;
    logic [DRW-1:0]    dr_cnt;
    logic [LAT-1:0]    pv, pl;
    logic [LOG2NT-1:0] pt [LAT];
    logic              issue, seq_last, drain_end;

    always_comb begin
        tone_inc  = tone + LOG2NT'(1);
        nco_clken = (state == S_RUN || state == S_DRAIN) && dn_ready;
        issue     = (state == S_RUN) && nco_clken;
        seq_last  = issue && !(dcnt < dwell_q) && (tone == last_q) && !loop_q;
        drain_end = (state == S_DRAIN) && nco_clken && (dr_cnt == DRW'(LAT - 1));
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (stop || seq_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            nco_phi_inc <= '0;
            tone        <= '0;
            dcnt        <= '0;
            last_q      <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            dr_cnt      <= '0;
            pv          <= '0;
            pl          <= '0;
            for (int i = 0; i < NTONE; i++) table_q[i] <= '0;
            for (int i = 0; i < LAT; i++) pt[i] <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_we) table_q[cfg_addr] <= cfg_data;

            // run parameters are captured once so reconfiguration mid-run cannot disturb it
            if (state == S_IDLE && start) begin
                tone        <= '0;
                dcnt        <= '0;
                nco_phi_inc <= table_q[0];
                last_q      <= last_tone;
                dwell_q     <= dwell;
                loop_q      <= loop_en;
            end

            if (issue) begin
                if (dcnt < dwell_q) begin
                    dcnt <= dcnt + DWW'(1);
                end else begin
                    dcnt <= '0;
                    if (tone < last_q) begin
                        tone        <= tone_inc;
                        nco_phi_inc <= table_q[tone_inc];
                    end else if (loop_q) begin
                        tone        <= '0;
                        nco_phi_inc <= table_q[0];
                    end
                end
            end

            if (state == S_RUN)
                dr_cnt <= '0;
            else if (state == S_DRAIN && nco_clken)
                dr_cnt <= dr_cnt + DRW'(1);

            // tag pipe advances in lockstep with the NCO pipeline
            if (nco_clken) begin
                pv    <= {pv[LAT-2:0], (state == S_RUN)};
                pl    <= {pl[LAT-2:0], seq_last};
                pt[0] <= tone;
                for (int i = 1; i < LAT; i++) pt[i] <= pt[i-1];
            end
        end
    end

    assign samp_valid = nco_clken & nco_out_valid & pv[LAT-1];
    assign samp_tone  = pt[LAT-1];
    assign samp_last  = samp_valid & pl[LAT-1];
    assign busy       = (state != S_IDLE);
    assign done       = drain_end;

endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Bench for nco_tone_sequencer: vector table, random runs and hand-written corner sequences.
module tb_nco_tone_sequencer;
    localparam int APR = 32, NTONE = 8, LOG2NT = 3, DWW = 16, LAT = 6;

    logic              clk, reset, cfg_we, loop_en, start, stop, dn_ready, nco_out_valid;
    logic [LOG2NT-1:0] cfg_addr, last_tone, samp_tone;
    logic [APR-1:0]    cfg_data, nco_phi_inc;
    logic [DWW-1:0]    dwell;
    logic              nco_clken, samp_valid, samp_last, busy, done;

    nco_tone_sequencer #(.APR(APR), .NTONE(NTONE), .LOG2NT(LOG2NT), .DWW(DWW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .last_tone(last_tone), .dwell(dwell), .loop_en(loop_en), .start(start), .stop(stop),
        .dn_ready(dn_ready), .nco_out_valid(nco_out_valid), .nco_phi_inc(nco_phi_inc),
        .nco_clken(nco_clken), .samp_valid(samp_valid), .samp_tone(samp_tone),
        .samp_last(samp_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          last;
        int          dwl;
        bit          lp;
        int          rdy;      // 0 always ready, 1 toggling, 2 random
        int          stop_at;  // issues seen before stop is pulsed (0 = never)
        bit          stop_rdy; // dn_ready during the stop cycle
        logic [31:0] t0;
        int          exp_n;
        int          exp_nl;
    } vec_t;

    vec_t           vecs [8];
    int             n_vec = 0, n_err = 0;
    logic [APR-1:0] tbl [NTONE];
    logic [APR-1:0] clk_phis[$], dly[$];
    logic [APR-1:0] al;
    int             obs_tone[$];
    bit             obs_last[$];
    int             n_done, done_idx;
    bit             chk_align;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // NCO stand-in: a sample emerges LAT enabled cycles after its phase increment was presented
    always @(negedge clk) begin
        if (!reset) begin
            al = '0;
            if (nco_clken) begin
                clk_phis.push_back(nco_phi_inc);
                dly.push_back(nco_phi_inc);
                if (dly.size() > LAT) al = dly.pop_front();
            end
            if (samp_valid) begin
                obs_tone.push_back(int'(samp_tone));
                obs_last.push_back(samp_last);
                if (chk_align) chk("align", al, tbl[samp_tone]);
            end
            if (samp_last && !samp_valid) chk("last_qual", samp_last, 0);
            if (done) begin
                n_done++;
                done_idx = clk_phis.size() - 1;
            end
        end
    end

    task automatic wr(input int a, input logic [APR-1:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = LOG2NT'(a); cfg_data = d; tbl[a] = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic clear_mon();
        clk_phis.delete(); dly.delete(); obs_tone.delete(); obs_last.delete();
        n_done = 0; done_idx = -1;
    endtask

    task automatic run_seq(input vec_t v);
        int cyc, nl;
        bit stopped;
        int exp_t[$];
        bit exp_l[$];
        wr(0, v.t0);
        last_tone = LOG2NT'(v.last); dwell = DWW'(v.dwl); loop_en = v.lp;
        @(posedge clk); #1;
        clear_mon(); chk_align = 1'b1;
        start = 1'b1; stop = 1'b1; dn_ready = 1'b1;  // start beats a simultaneous stop
        cyc = 0; stopped = 1'b0;
        while (n_done == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            case (v.rdy)
                0:       dn_ready = 1'b1;
                1:       dn_ready = ((cyc % 2) == 1);
                default: dn_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (v.stop_at != 0 && !stopped && clk_phis.size() == v.stop_at) begin
                stop = 1'b1; dn_ready = v.stop_rdy; stopped = 1'b1;
            end
            cyc++;
        end
        chk("done_seen", (n_done != 0), 1);
        dn_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", n_done, 1);
        chk("idle_after", busy, 0);

        // expected tags: whole passes over tones 0..last, each repeated dwell+1 times
        do begin
            for (int t = 0; t <= v.last; t++)
                for (int k = 0; k <= v.dwl; k++)
                    if (!v.lp || exp_t.size() < v.exp_n) begin
                        exp_t.push_back(t); exp_l.push_back(1'b0);
                    end
        end while (v.lp && exp_t.size() < v.exp_n);
        if (!v.lp) exp_l[exp_l.size()-1] = 1'b1;

        chk("n_samp", obs_tone.size(), v.exp_n);
        chk("n_model", exp_t.size(), v.exp_n);
        nl = 0;
        foreach (obs_last[i]) nl += int'(obs_last[i]);
        chk("n_last", nl, v.exp_nl);
        for (int i = 0; i < exp_t.size() && i < obs_tone.size(); i++) begin
            chk("tag_tone", obs_tone[i], exp_t[i]);
            chk("tag_last", obs_last[i], exp_l[i]);
        end
        for (int i = 0; i < exp_t.size() && i < clk_phis.size(); i++)
            chk("issue_phi", clk_phis[i], tbl[exp_t[i]]);
        chk("done_time", done_idx, v.exp_n - 1 + LAT);
    endtask

    initial begin
        int cyc;
        bit wrote, stopped;
        vec_t rv;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; last_tone = '0; dwell = '0;
        loop_en = 1'b0; start = 1'b0; stop = 1'b0; dn_ready = 1'b1; nco_out_valid = 1'b1;
        chk_align = 1'b1; n_done = 0; done_idx = -1;
        for (int i = 0; i < NTONE; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phi", nco_phi_inc, 0);
        chk("rst_clken", nco_clken, 0);
        chk("rst_valid", samp_valid, 0);
        chk("rst_tone", samp_tone, 0);
        chk("rst_last", samp_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NTONE; i++) wr(i, APR'((i + 1) * 100));

        vecs[0] = '{2, 3, 1'b0, 0, 0,  1'b0, 32'd100,        12, 1};
        vecs[1] = '{2, 3, 1'b1, 0, 7,  1'b1, 32'd100,        8,  0};
        vecs[2] = '{2, 3, 1'b1, 0, 7,  1'b0, 32'd100,        7,  0};
        vecs[3] = '{2, 3, 1'b0, 1, 0,  1'b0, 32'd100,        12, 1};
        vecs[4] = '{0, 0, 1'b0, 0, 0,  1'b0, 32'h4000_0000,  1,  1};
        vecs[5] = '{7, 0, 1'b0, 1, 0,  1'b0, 32'd100,        8,  1};
        vecs[6] = '{4, 1, 1'b1, 2, 13, 1'b0, 32'd100,        13, 0};
        vecs[7] = '{7, 2, 1'b1, 1, 30, 1'b1, 32'd100,        31, 0};
        foreach (vecs[i]) run_seq(vecs[i]);

        for (int r = 0; r < 12; r++) begin
            for (int i = 1; i < NTONE; i++) wr(i, $urandom);
            rv.last = $urandom_range(0, NTONE - 1);
            rv.dwl = $urandom_range(0, 3);
            rv.lp = 1'($urandom_range(0, 1));
            rv.rdy = 2;
            rv.stop_at = rv.lp ? $urandom_range(1, 40) : 0;
            rv.stop_rdy = 1'($urandom_range(0, 1));
            rv.t0 = $urandom;
            rv.exp_n = rv.lp ? rv.stop_at + int'(rv.stop_rdy) : (rv.last + 1) * (rv.dwl + 1);
            rv.exp_nl = rv.lp ? 0 : 1;
            run_seq(rv);
        end

        // start while busy plus a write to the active tone
        wr(0, 100); wr(1, 200); wr(2, 300);
        last_tone = 2; dwell = 3; loop_en = 1'b1;
        @(posedge clk); #1;
        clear_mon(); chk_align = 1'b0; start = 1'b1;
        cyc = 0; wrote = 1'b0; stopped = 1'b0;
        while (n_done == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0; cfg_we = 1'b0; dn_ready = 1'b1;
            if (clk_phis.size() == 2 && !wrote) begin
                cfg_we = 1'b1; cfg_addr = 0; cfg_data = 555; start = 1'b1; wrote = 1'b1;
            end
            if (clk_phis.size() == 16 && !stopped) begin
                stop = 1'b1; dn_ready = 1'b0; stopped = 1'b1;
            end
            cyc++;
        end
        tbl[0] = 555;
        chk("busy_done_seen", (n_done != 0), 1);
        chk("busy_nsamp", obs_tone.size(), 16);
        for (int i = 0; i < 16 && i < clk_phis.size(); i++)
            chk("busy_phi", clk_phis[i], (i < 12) ? APR'((i / 4 + 1) * 100) : APR'(555));
        for (int i = 0; i < 16 && i < obs_tone.size(); i++)
            chk("busy_tone", obs_tone[i], (i / 4) % 3);
        repeat (3) @(posedge clk);
        chk_align = 1'b1;

        // synchronous reset during RUN
        wr(0, 100);
        last_tone = 2; dwell = 3; loop_en = 1'b0;
        @(posedge clk); #1;
        clear_mon(); start = 1'b1;
        cyc = 0;
        while (clk_phis.size() < 5 && cyc < 200) begin
            @(posedge clk); #1;
            start = 1'b0; cyc++;
        end
        chk("rst_reach5", clk_phis.size(), 5);
        chk("rst_busy_pre", busy, 1);
        reset = 1'b1; n_done = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_clken", nco_clken, 0);
        chk("mid_valid", samp_valid, 0);
        chk("mid_phi", nco_phi_inc, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_nodone", n_done, 0);
        chk("mid_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
